// File: rtl/jpeg_pkg.sv
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared constants, zigzag LUT and symbol type for zigzag_rle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_pkg;

    localparam int COEF_W     = 10;
    localparam int AMP_W      = COEF_W + 1;
    localparam int BLOCK_SIZE = 64;
    localparam logic [3:0] ZRL_RUN = 4'd15;

    // zigzag index -> raster address within an 8x8 block
    localparam logic [5:0] ZIGZAG_LUT [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef struct packed {
        logic                    dc;
        logic [3:0]              run;
        logic [3:0]              size;
        logic signed [AMP_W-1:0] amp;
        logic                    last;
    } symbol_t;

    function automatic symbol_t make_sym(input logic dc, input logic [3:0] run,
                                         input logic [3:0] size,
                                         input logic signed [AMP_W-1:0] amp,
                                         input logic last);
        symbol_t s;
        s.dc   = dc;
        s.run  = run;
        s.size = size;
        s.amp  = amp;
        s.last = last;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/coef_size_cat.sv
// ============================================================================
// Module      : coef_size_cat
// Description : Combinational JPEG magnitude category (bits needed for |value|).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module coef_size_cat #(
    parameter int WIDTH = 11
) (
    input  logic signed [WIDTH-1:0] value,
    output logic [3:0]              size
);

    logic [WIDTH-1:0] w_mag;

    // the most negative value still yields the correct unsigned magnitude
    always_comb begin
        w_mag = value[WIDTH-1] ? (~value + 1'b1) : value;
        size  = 4'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_mag[i]) size = 4'(i + 1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/zigzag_rle.sv
// ============================================================================
// Module      : zigzag_rle
// Description : Ping-pong 8x8 block buffer, zigzag scan and JPEG run-length
//               symbol generator. Define ZIGZAG_DC_DPCM_EN for DC prediction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int DATA_WIDTH = COEF_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  frame_start,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_dc,
    output logic [3:0]            out_run,
    output logic [3:0]            out_size,
    output logic [DATA_WIDTH:0]   out_amp,
    output logic                  out_last,
    output logic                  overflow
);

    localparam int AW = DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DC   = 3'd1,
        S_SCAN = 3'd2,
        S_ZRL  = 3'd3,
        S_EOB  = 3'd4
    } state_t;

    logic signed [DATA_WIDTH-1:0] mem [0:2*BLOCK_SIZE-1];
    logic signed [DATA_WIDTH-1:0] r_rdata;

    logic       r_wbank, r_rbank, r_overflow;
    logic [5:0] r_wcount;
    logic [1:0] r_full, w_full_next;

    state_t  r_state;
    symbol_t r_sym;
    logic    r_valid, r_dc_load;
    logic [5:0] r_k, r_run, w_ridx;

    logic w_accept, w_release, w_wr_ok, w_wr, w_free, w_ren;
    logic w_cur_zero, w_k_last, w_run_big;
    logic signed [AW-1:0] w_ac_amp, w_dc_amp, w_cat_in;
    logic [3:0] w_size;

    assign w_accept  = r_valid & out_ready;
    assign w_release = w_accept & r_sym.last;
    assign w_wr_ok   = !r_full[r_wbank] || (w_release && (r_rbank == r_wbank));
    assign w_wr      = in_valid & w_wr_ok;
    assign w_free    = !r_valid || out_ready;

    assign w_cur_zero = (r_rdata == '0);
    assign w_k_last   = (r_k == 6'd63);
    assign w_run_big  = (r_run >= 6'd16);
    assign w_ac_amp   = AW'(r_rdata);

    // ---------------- write side ----------------
    always_comb begin
        w_full_next = r_full;
        if (w_release) w_full_next[r_rbank] = 1'b0;
        if (w_wr && (r_wcount == 6'd63)) w_full_next[r_wbank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem[{r_wbank, r_wcount}] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbank    <= 1'b0;
            r_wcount   <= 6'd0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_wr) begin
                r_wcount <= r_wcount + 6'd1;
                if (r_wcount == 6'd63) r_wbank <= ~r_wbank;
            end else if (in_valid) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- DC amplitude ----------------
`ifdef ZIGZAG_DC_DPCM_EN
    logic signed [DATA_WIDTH-1:0] r_pred, r_dc_val;

    assign w_dc_amp = AW'(r_rdata) - AW'(r_pred);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred   <= '0;
            r_dc_val <= '0;
        end else begin
            if (r_state == S_DC && r_dc_load) r_dc_val <= r_rdata;
            // frame_start takes priority over a DC acceptance in the same cycle
            if (frame_start)
                r_pred <= '0;
            else if (r_state == S_DC && !r_dc_load && w_accept)
                r_pred <= r_dc_val;
        end
    end
`else
    logic w_unused_frame_start;

    assign w_dc_amp             = AW'(r_rdata);
    assign w_unused_frame_start = frame_start;
`endif

    assign w_cat_in = (r_state == S_DC) ? w_dc_amp : w_ac_amp;

    coef_size_cat #(
        .WIDTH (AW)
    ) u_size_cat (
        .value (w_cat_in),
        .size  (w_size)
    );

    // ---------------- read side ----------------
    // Read requests mirror the FSM decisions below; r_rdata holds index r_k.
    always_comb begin
        w_ren  = 1'b0;
        w_ridx = 6'd0;
        case (r_state)
            S_IDLE: if (r_full[r_rbank]) w_ren = 1'b1;
            S_DC: if (r_dc_load) begin
                w_ren  = 1'b1;
                w_ridx = 6'd1;
            end
            S_SCAN: if (w_free && !w_release && !w_k_last && (w_cur_zero || !w_run_big)) begin
                w_ren  = 1'b1;
                w_ridx = r_k + 6'd1;
            end
            S_ZRL: if (w_accept && !w_run_big && !w_k_last) begin
                w_ren  = 1'b1;
                w_ridx = r_k + 6'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ren) r_rdata <= mem[{r_rbank, ZIGZAG_LUT[w_ridx]}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_sym     <= '0;
            r_dc_load <= 1'b0;
            r_k       <= 6'd0;
            r_run     <= 6'd0;
            r_rbank   <= 1'b0;
        end else begin
            if (w_release) r_rbank <= ~r_rbank;
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rbank]) begin
                        r_state   <= S_DC;
                        r_dc_load <= 1'b1;
                    end
                end
                S_DC: begin
                    if (r_dc_load) begin
                        r_dc_load <= 1'b0;
                        r_valid   <= 1'b1;
                        r_sym     <= make_sym(1'b1, 4'd0, w_size, AMP_W'(w_dc_amp), 1'b0);
                        r_k       <= 6'd1;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                        r_run   <= 6'd0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_release) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_free) begin
                        if (w_cur_zero) begin
                            if (w_k_last) begin
                                r_valid <= 1'b1;
                                r_sym   <= make_sym(1'b0, 4'd0, 4'd0, '0, 1'b1);
                                r_state <= S_EOB;
                            end else begin
                                r_valid <= 1'b0;
                                r_run   <= r_run + 6'd1;
                                r_k     <= r_k + 6'd1;
                            end
                        end else if (w_run_big) begin
                            r_valid <= 1'b1;
                            r_sym   <= make_sym(1'b0, ZRL_RUN, 4'd0, '0, 1'b0);
                            r_run   <= r_run - 6'd16;
                            r_state <= S_ZRL;
                        end else begin
                            r_valid <= 1'b1;
                            r_sym   <= make_sym(1'b0, r_run[3:0], w_size, AMP_W'(w_ac_amp), w_k_last);
                            r_run   <= 6'd0;
                            if (!w_k_last) r_k <= r_k + 6'd1;
                        end
                    end
                end
                S_ZRL: begin
                    if (w_accept) begin
                        if (w_run_big) begin
                            r_sym <= make_sym(1'b0, ZRL_RUN, 4'd0, '0, 1'b0);
                            r_run <= r_run - 6'd16;
                        end else begin
                            r_sym   <= make_sym(1'b0, r_run[3:0], w_size, AMP_W'(w_ac_amp), w_k_last);
                            r_run   <= 6'd0;
                            r_state <= S_SCAN;
                            if (!w_k_last) r_k <= r_k + 6'd1;
                        end
                    end
                end
                S_EOB: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_valid;
    assign out_dc    = r_sym.dc;
    assign out_run   = r_sym.run;
    assign out_size  = r_sym.size;
    assign out_amp   = (DATA_WIDTH+1)'(r_sym.amp);
    assign out_last  = r_sym.last;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_zigzag_rle.sv
// ============================================================================
// Module      : tb_zigzag_rle
// Description : Scoreboard bench for zigzag_rle (expected symbols queued at
//               stimulus time, popped by an independent output monitor).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zigzag_rle;

    localparam int DW = 10;

    typedef struct packed {
        logic               dc;
        logic [3:0]         run;
        logic [3:0]         size;
        logic signed [10:0] amp;
        logic               last;
    } sym_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 frame_start = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 out_valid, out_dc, out_last, overflow;
    logic [3:0]           out_run, out_size;
    logic [DW:0]          out_amp;

    zigzag_rle #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_dc      (out_dc),
        .out_run     (out_run),
        .out_size    (out_size),
        .out_amp     (out_amp),
        .out_last    (out_last),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    sym_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   nsym = 0;
    int   ready_mode = 1;
    logic signed [DW-1:0] blk [64];

    sym_t mon_act, mon_exp, stall_sym;
    logic stall_prev = 1'b0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        mon_act = {out_dc, out_run, out_size, out_amp, out_last};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!out_valid || mon_act !== stall_sym) begin
                    bad++;
                    $display("FAIL hold: got valid=%0d sym=%h, want valid=1 sym=%h",
                             out_valid, mon_act, stall_sym);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_symbol#%0d: got dc=%0d run=%0d size=%0d amp=%0d last=%0d, want none",
                             nsym, mon_act.dc, mon_act.run, mon_act.size, mon_act.amp, mon_act.last);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL symbol#%0d: got dc=%0d run=%0d size=%0d amp=%0d last=%0d, want dc=%0d run=%0d size=%0d amp=%0d last=%0d",
                                 nsym, mon_act.dc, mon_act.run, mon_act.size, mon_act.amp, mon_act.last,
                                 mon_exp.dc, mon_exp.run, mon_exp.size, mon_exp.amp, mon_exp.last);
                    end
                end
                nsym++;
            end
            stall_prev = out_valid && !out_ready;
            stall_sym  = mon_act;
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic push(input logic dc, input int run, input int size, input int amp, input logic last);
        sym_t s;
        s.dc   = dc;
        s.run  = 4'(run);
        s.size = 4'(size);
        s.amp  = 11'(amp);
        s.last = last;
        exp_q.push_back(s);
    endtask

    task automatic push_dc(input int amp, input int size);
        push(1'b1, 0, size, amp, 1'b0);
    endtask

    task automatic push_zrl();
        push(1'b0, 15, 0, 0, 1'b0);
    endtask

    task automatic push_eob();
        push(1'b0, 0, 0, 0, 1'b1);
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    task automatic send_block();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = blk[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size() + int'(out_valid), 0);
        repeat (4) tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_valid"}, int'(out_valid), 0);
        check({name, "_fields"}, int'({out_dc, out_run, out_size, out_amp, out_last}), 0);
        check({name, "_overflow"}, int'(overflow), 0);
    endtask

    // block with AC -3 at zz1 and 2 at zz2
    task automatic load_blk_t2();
        clear_blk();
        blk[1] = -10'sd3;
        blk[8] = 10'sd2;
        push_dc(0, 0);
        push(1'b0, 0, 2, -3, 1'b0);
        push(1'b0, 0, 2, 2, 1'b0);
        push_eob();
    endtask

    // block whose only nonzero is the final zigzag coefficient
    task automatic load_blk_t3();
        clear_blk();
        blk[63] = 10'sd1;
        push_dc(0, 0);
        push_zrl();
        push_zrl();
        push_zrl();
        push(1'b0, 14, 1, 1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // DC only, with first-symbol latency bound
        ready_mode = 1;
        clear_blk();
        blk[0] = 10'sd5;
        push_dc(5, 3);
        push_eob();
        send_block();
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        check("dc_latency_found", int'(found), 1);
        drain(300);

        pulse_fs();
        load_blk_t2();
        send_block();
        drain(300);

        pulse_fs();
        load_blk_t3();
        send_block();
        drain(300);

        // back-to-back blocks under random backpressure
        pulse_fs();
        ready_mode = 2;
        clear_blk();
        blk[16] = -10'sd300;
        blk[2]  = 10'sd7;
        push_dc(0, 0);
        push(1'b0, 2, 9, -300, 1'b0);
        push(1'b0, 1, 3, 7, 1'b0);
        push_eob();
        send_block();
        clear_blk();
        blk[5]  = 10'sd511;
        blk[63] = -10'sd512;
        push_dc(0, 0);
        push(1'b0, 14, 9, 511, 1'b0);
        push_zrl();
        push_zrl();
        push(1'b0, 15, 10, -512, 1'b1);
        send_block();
        drain(3000);
        check("overflow_after_b2b", int'(overflow), 0);
        ready_mode = 1;
        tick();

        // DC values through the predictor
        pulse_fs();
        clear_blk();
        blk[0] = 10'sd10;
        push_dc(10, 4);
        push_eob();
        send_block();
        drain(300);
        clear_blk();
        blk[0] = 10'sd7;
`ifdef ZIGZAG_DC_DPCM_EN
        push_dc(-3, 2);
`else
        push_dc(7, 3);
`endif
        push_eob();
        send_block();
        drain(300);
        pulse_fs();
        clear_blk();
        blk[0] = 10'sd4;
        push_dc(4, 3);
        push_eob();
        send_block();
        drain(300);

        // three blocks while stalled: third is dropped
        pulse_fs();
        ready_mode = 0;
        out_ready  = 1'b0;
        load_blk_t2();
        send_block();
        load_blk_t3();
        send_block();
        clear_blk();
        blk[1] = 10'sd1;
        send_block();
        repeat (10) tick();
        check("overflow_set", int'(overflow), 1);
        check("stalled_valid", int'(out_valid), 1);
        ready_mode = 1;
        drain(1000);
        check("overflow_sticky", int'(overflow), 1);

        rst = 1'b1;
        tick();
        check_outputs_zero("rerst");
        rst = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
